clk_step_ctrl: RTL
==================

CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter: DIV_W, 32, width of divisor register and counter.
REQ-002 Parameter: DEFAULT_DIV, 32'd100, divisor value loaded at reset.
REQ-003 Port: clk0  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: mode  input  2  00 halt, 01 run, 10 single-step, 11 reserved (treated as halt).
REQ-006 Port: step_btn  input  1  step request level, already synchronized to clk0.
REQ-007 Port: div_val  input  DIV_W  new divisor value.
REQ-008 Port: div_load  input  1  one-cycle strobe; captures div_val.
REQ-009 Port: div_ack  output  1  one-cycle pulse acknowledging div_load.
REQ-010 Port: cpu_ce  output  1  registered CPU clock-enable pulse, one cycle wide.
REQ-011 Port: running  output  1  high while state is RUN.
REQ-012 Port: tick_cnt  output  32  count of cpu_ce pulses issued.

Function
REQ-013 States SHALL be HALT, RUN, STEP_WAIT, STEP_PULSE.
REQ-014 Transition priority each cycle: mode 00/11 -> HALT; mode 01 -> RUN; mode 10 -> STEP_WAIT, except STEP_WAIT with step_btn rising edge -> STEP_PULSE.
REQ-015 STEP_PULSE SHALL last exactly one cycle, then go to STEP_WAIT (or per REQ-014 if mode changed).
REQ-016 Rising edge of step_btn = step_btn high and registered previous value low; holding step_btn high SHALL yield one pulse only.
REQ-017 A step edge coinciding with a mode change away from 10 SHALL be discarded.
REQ-018 In RUN, counter cnt SHALL count 0..div_act-1, wrap to 0, and cpu_ce SHALL be 1 in the cycle after cnt == div_act-1 (period div_act cycles).
REQ-019 cnt SHALL be cleared to 0 in every cycle state is not RUN; first RUN pulse appears div_act cycles after RUN entry.
REQ-020 In STEP_PULSE, cpu_ce SHALL be 1 for that cycle only; in HALT and STEP_WAIT cpu_ce SHALL be 0.
REQ-021 div_load SHALL capture div_val into div_pend and set a pending flag; div_ack SHALL pulse the following cycle, irrespective of state.
REQ-022 Pending divisor SHALL transfer to div_act at the next RUN wrap, or immediately if state is not RUN.
REQ-023 div_val of 0 SHALL be stored as 1 (cpu_ce every cycle in RUN).
REQ-024 div_load during an existing pending load SHALL overwrite div_pend; only latest value applies.
REQ-025 tick_cnt SHALL increment by 1 on every cpu_ce, wrapping 32'hFFFFFFFF -> 0.
REQ-026 running SHALL be a registered decode of state == RUN.

Reset
REQ-027 On rst_n low, immediately: state HALT, cnt 0, div_act and div_pend DEFAULT_DIV, pending 0, step_btn history 0, cpu_ce 0, div_ack 0, running 0, tick_cnt 0.
REQ-028 Reset assertion mid-RUN or mid-STEP_PULSE SHALL drop cpu_ce in the same instant, no completing pulse.
REQ-029 After rst_n release, first state change SHALL occur on the first clk0 rising edge with rst_n high.

Verification
REQ-030 Reset, mode=01, default div 100 -> cpu_ce pulses every 100 cycles, first 100 cycles after RUN entry; tick_cnt=5 after 500 cycles.
REQ-031 mode=10, step_btn high for 20 cycles, three times -> exactly 3 one-cycle cpu_ce pulses, tick_cnt=3, running=0.
REQ-032 RUN div=100, div_load div_val=4 at cnt=10 -> div_ack next cycle; next pulse still at cnt 99, then pulses every 4 cycles.
REQ-033 HALT, div_load div_val=0, then mode=01 -> cpu_ce high every cycle.
REQ-034 RUN div=2, rst_n low at cpu_ce=1 -> cpu_ce, tick_cnt, running 0 immediately; after release state HALT, div_act=100.
REQ-035 mode 10 -> 01 on same cycle as step_btn rising edge -> no step pulse; RUN timing per REQ-019.

Source files
------------

// File: rtl/clk_step_ctrl_if.sv
// Control/status bundle for clk_step_ctrl: mode and divisor programming in, CPU enable out.
interface clk_step_ctrl_if #(
    parameter int unsigned DIV_W = 32
);
    logic [1:0]       mode;
    logic             step_btn;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             div_ack;
    logic             cpu_ce;
    logic             running;
    logic [31:0]      tick_cnt;

    modport master (
        output mode, step_btn, div_val, div_load,
        input  div_ack, cpu_ce, running, tick_cnt
    );

    modport slave (
        input  mode, step_btn, div_val, div_load,
        output div_ack, cpu_ce, running, tick_cnt
    );
endinterface

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable generator with halt, free-run (divided) and single-step modes.
// A newly loaded divisor takes effect at the next run-mode wrap, or at once outside run mode.
module clk_step_ctrl #(
    parameter int unsigned      DIV_W       = 32,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(100)
) (
    input  logic           clk0,
    input  logic           rst_n,
    clk_step_ctrl_if.slave io_ctrl
);
    typedef enum logic [1:0] {StHalt, StRun, StStepWait, StStepPulse} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_pend;
    logic [DIV_W-1:0] w_div_in;
    logic             r_pending;
    logic             r_btn_prev;
    logic             r_cpu_ce;
    logic             r_div_ack;
    logic             r_running;
    logic [31:0]      r_tick_cnt;
    logic             w_step_edge;
    logic             w_wrap;
    logic             w_ce_next;
    logic             w_transfer;

    assign w_step_edge = io_ctrl.step_btn & ~r_btn_prev;
    assign w_wrap      = (r_state == StRun) && (r_cnt == r_div_act - DIV_W'(1));
    assign w_div_in    = (io_ctrl.div_val == '0) ? DIV_W'(1) : io_ctrl.div_val;
    assign w_transfer  = r_pending && ((r_state != StRun) || w_wrap);

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StHalt;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A step edge only counts while already waiting in step mode.
    always_comb begin
        w_state_next = StHalt;
        case (io_ctrl.mode)
            2'b01:   w_state_next = StRun;
            2'b10:   w_state_next = ((r_state == StStepWait) && w_step_edge) ? StStepPulse
                                                                             : StStepWait;
            default: w_state_next = StHalt;
        endcase
    end

    // Counter only advances while staying in run; any other path clears it.
    always_comb begin
        w_ce_next  = 1'b0;
        w_cnt_next = '0;
        if (w_state_next == StStepPulse) begin
            w_ce_next = 1'b1;
        end
        if ((r_state == StRun) && (w_state_next == StRun)) begin
            w_ce_next  = w_wrap;
            w_cnt_next = w_wrap ? '0 : r_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_cpu_ce   <= 1'b0;
            r_running  <= 1'b0;
            r_tick_cnt <= '0;
            r_btn_prev <= 1'b0;
            r_div_ack  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_cpu_ce   <= w_ce_next;
            r_running  <= (w_state_next == StRun);
            r_btn_prev <= io_ctrl.step_btn;
            r_div_ack  <= io_ctrl.div_load;
            if (w_ce_next) begin
                r_tick_cnt <= r_tick_cnt + 32'd1;
            end
        end
    end

    // A load in the same cycle as a transfer wins the pending slot for the next transfer.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_div_act  <= DEFAULT_DIV;
            r_div_pend <= DEFAULT_DIV;
            r_pending  <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_div_act <= r_div_pend;
            end
            if (io_ctrl.div_load) begin
                r_div_pend <= w_div_in;
                r_pending  <= 1'b1;
            end else if (w_transfer) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign io_ctrl.cpu_ce   = r_cpu_ce;
    assign io_ctrl.running  = r_running;
    assign io_ctrl.div_ack  = r_div_ack;
    assign io_ctrl.tick_cnt = r_tick_cnt;
endmodule
